// File: rtl/audio_dac_tx.sv
// Serial audio transmitter: frame FIFO feeding an I2S / left-justified serialiser
// slaved to codec BCLK/LRCK, which are synchronised and sampled in the clk domain.
module audio_dac_tx #(
  parameter int unsigned WIDTH            = 16,
  parameter int unsigned FIFO_DEPTH       = 4,
  parameter int unsigned MODE             = 0,
  parameter int unsigned HOLD_ON_UNDERRUN = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  input  logic [WIDTH-1:0]                in_left,
  input  logic [WIDTH-1:0]                in_right,
  output logic                            in_ready,
  input  logic                            AUD_BCLK,
  input  logic                            AUD_DACLRCK,
  output logic                            AUD_DACDAT,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            underrun,
  output logic [15:0]                     underrun_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_SHIFT, S_PAD} state_t;

  logic          bclk_s1, bclk_s2, bclk_prev;
  logic          lrck_s1, lrck_s2, lrck_prev;
  logic          lrck_last;
  logic          bclk_fall, slot_start, slot_left, frame_start;
  logic          fifo_empty, push, pop;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [2*WIDTH-1:0] mem [FIFO_DEPTH];
  logic [2*WIDTH-1:0] rd_data;
  logic [WIDTH-1:0]   new_word, shreg, right_hold, last_l, last_r;
  logic [CW-1:0]      cnt;
  state_t             state;

  // Codec clock synchronisers with one history flop each
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bclk_s1   <= 1'b0;
      bclk_s2   <= 1'b0;
      bclk_prev <= 1'b0;
      lrck_s1   <= 1'b0;
      lrck_s2   <= 1'b0;
      lrck_prev <= 1'b0;
    end else begin
      bclk_s1   <= AUD_BCLK;
      bclk_s2   <= bclk_s1;
      bclk_prev <= bclk_s2;
      lrck_s1   <= AUD_DACLRCK;
      lrck_s2   <= lrck_s1;
      lrck_prev <= lrck_s2;
    end
  end

  assign bclk_fall   = bclk_prev & ~bclk_s2;
  assign slot_start  = bclk_fall & (lrck_s2 != lrck_last);
  assign slot_left   = (MODE == 1) ? lrck_s2 : ~lrck_s2;
  assign frame_start = slot_start & slot_left;

  assign fifo_empty = (fifo_level == '0);
  assign in_ready   = (fifo_level < LW'(FIFO_DEPTH));
  assign push       = in_valid & in_ready;
  assign pop        = frame_start & ~fifo_empty;
  assign rd_data    = mem[rd_ptr];

  // Storage array carries no reset; validity is tracked by the level/pointers
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_left, in_right};
  end

  // Word loaded at a slot start: FIFO head, held frame on underrun, or right half of the current frame
  always_comb begin
    new_word = '0;
    if (slot_left) begin
      if (!fifo_empty)                new_word = rd_data[2*WIDTH-1:WIDTH];
      else if (HOLD_ON_UNDERRUN != 0) new_word = last_l;
    end else begin
      new_word = right_hold;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_level     <= '0;
      lrck_last      <= 1'b0;
      underrun       <= 1'b0;
      underrun_count <= '0;
      right_hold     <= '0;
      last_l         <= '0;
      last_r         <= '0;
    end else begin
      underrun <= 1'b0;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
      if (bclk_fall) lrck_last <= lrck_s2;
      if (frame_start) begin
        if (!fifo_empty) begin
          last_l     <= rd_data[2*WIDTH-1:WIDTH];
          last_r     <= rd_data[WIDTH-1:0];
          right_hold <= rd_data[WIDTH-1:0];
        end else begin
          underrun <= 1'b1;
          if (underrun_count != 16'hFFFF) underrun_count <= underrun_count + 16'd1;
          right_hold <= (HOLD_ON_UNDERRUN != 0) ? last_r : '0;
        end
      end
    end
  end

  // Serialiser FSM; any slot start aborts the current word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      shreg      <= '0;
      cnt        <= '0;
      AUD_DACDAT <= 1'b0;
    end else if (bclk_fall) begin
      if (slot_start && (slot_left || state != S_IDLE)) begin
        if (MODE == 1) begin
          AUD_DACDAT <= new_word[WIDTH-1];
          shreg      <= {new_word[WIDTH-2:0], 1'b0};
          cnt        <= CW'(WIDTH - 1);
          state      <= S_SHIFT;
        end else begin
          AUD_DACDAT <= 1'b0;
          shreg      <= new_word;
          state      <= S_DELAY;
        end
      end else begin
        case (state)
          S_DELAY: begin
            AUD_DACDAT <= shreg[WIDTH-1];
            shreg      <= {shreg[WIDTH-2:0], 1'b0};
            cnt        <= CW'(WIDTH - 1);
            state      <= S_SHIFT;
          end
          S_SHIFT: begin
            if (cnt == '0) begin
              AUD_DACDAT <= 1'b0;
              state      <= S_PAD;
            end else begin
              AUD_DACDAT <= shreg[WIDTH-1];
              shreg      <= {shreg[WIDTH-2:0], 1'b0};
              cnt        <= cnt - CW'(1);
            end
          end
          default: AUD_DACDAT <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_audio_dac_tx.sv
// Bench for audio_dac_tx: an I2S/hold instance and a left-justified/24-bit/zero-fill
// instance share BCLK/LRCK; a frame-queue model predicts every slot's bit pattern.
module tb_audio_dac_tx;

  logic clk = 1'b0;
  logic rst_n, bclk, lrck;
  logic valid_a, ready_a, dat_a, und_a;
  logic [15:0] left_a, right_a, ucount_a;
  logic [2:0]  level_a;
  logic valid_b, ready_b, dat_b, und_b;
  logic [23:0] left_b, right_b;
  logic [15:0] ucount_b;
  logic [2:0]  level_b;

  int vectors = 0;
  int miscompares = 0;

  int mode_m [2] = '{0, 1};
  int wid    [2] = '{16, 24};
  int hold   [2] = '{1, 0};
  bit started [2];
  logic [31:0] rhold [2], lastl [2], lastr [2];
  int ucnt [2];
  int utot [2];
  int ucyc_a = 0, ucyc_b = 0;
  logic last_lrck;
  int slot_no = 0;
  logic [63:0] qa [$];
  logic [63:0] qb [$];

  always #5 clk = ~clk;

  audio_dac_tx #(.WIDTH(16), .FIFO_DEPTH(4), .MODE(0), .HOLD_ON_UNDERRUN(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(valid_a), .in_left(left_a), .in_right(right_a),
    .in_ready(ready_a), .AUD_BCLK(bclk), .AUD_DACLRCK(lrck), .AUD_DACDAT(dat_a),
    .fifo_level(level_a), .underrun(und_a), .underrun_count(ucount_a));

  audio_dac_tx #(.WIDTH(24), .FIFO_DEPTH(4), .MODE(1), .HOLD_ON_UNDERRUN(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(valid_b), .in_left(left_b), .in_right(right_b),
    .in_ready(ready_b), .AUD_BCLK(bclk), .AUD_DACLRCK(lrck), .AUD_DACDAT(dat_b),
    .fifo_level(level_b), .underrun(und_b), .underrun_count(ucount_b));

  always @(posedge clk) begin
    if (und_a === 1'b1) ucyc_a <= ucyc_a + 1;
    if (und_b === 1'b1) ucyc_b <= ucyc_b + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_bit(input int d, input logic [31:0] w, input int k);
    int idx;
    if (mode_m[d] == 0) begin
      if (k == 0) return 1'b0;
      idx = k - 1;
    end else begin
      idx = k;
    end
    if (idx < wid[d]) return w[wid[d]-1-idx];
    return 1'b0;
  endfunction

  task automatic model_reset();
    qa.delete();
    qb.delete();
    for (int d = 0; d < 2; d++) begin
      started[d] = 1'b0;
      rhold[d] = '0;
      lastl[d] = '0;
      lastr[d] = '0;
      ucnt[d] = 0;
    end
    last_lrck = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
    valid_a = 1'b0;
    valid_b = 1'b0;
  endtask

  task automatic push(input int d, input logic [31:0] l, input logic [31:0] r);
    int t;
    t = 0;
    @(negedge clk);
    valid_a = 1'b0;
    valid_b = 1'b0;
    while (((d == 0) ? ready_a : ready_b) !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      check("push_ready_timeout", (d == 0) ? ready_a : ready_b, 1);
      return;
    end
    if (d == 0) begin
      valid_a = 1'b1; left_a = 16'(l); right_a = 16'(r);
      qa.push_back({l, r});
    end else begin
      valid_b = 1'b1; left_b = 24'(l); right_b = 24'(r);
      qb.push_back({l, r});
    end
    @(posedge clk);
  endtask

  // One BCLK period: falling edge (with LRCK update), then sample both data pins late in the period
  task automatic bclk_period(input logic lv, output logic oa, output logic ob);
    @(negedge clk);
    bclk = 1'b0;
    lrck = lv;
    repeat (4) @(negedge clk);
    bclk = 1'b1;
    repeat (4) @(negedge clk);
    oa = dat_a;
    ob = dat_b;
  endtask

  task automatic slot(input logic lv, input int n);
    logic [63:0] expv [2];
    logic [63:0] obsv [2];
    logic [31:0] word [2];
    logic [63:0] e;
    bit act, ss, isl, have;
    logic oa, ob;
    ss = (lv !== last_lrck);
    last_lrck = lv;
    slot_no++;
    for (int d = 0; d < 2; d++) begin
      act = 1'b0;
      word[d] = '0;
      expv[d] = '0;
      obsv[d] = '0;
      isl = (mode_m[d] != 0) ? lv : ~lv;
      if (ss && isl) begin
        started[d] = 1'b1;
        act = 1'b1;
        have = 1'b0;
        e = '0;
        if (d == 0 && qa.size() > 0) begin e = qa.pop_front(); have = 1'b1; end
        if (d == 1 && qb.size() > 0) begin e = qb.pop_front(); have = 1'b1; end
        if (have) begin
          lastl[d] = e[63:32]; lastr[d] = e[31:0];
          word[d] = e[63:32]; rhold[d] = e[31:0];
        end else begin
          ucnt[d]++;
          utot[d]++;
          if (hold[d] != 0) begin word[d] = lastl[d]; rhold[d] = lastr[d]; end
          else begin word[d] = '0; rhold[d] = '0; end
        end
      end else if (ss && started[d]) begin
        act = 1'b1;
        word[d] = rhold[d];
      end
      if (act)
        for (int k = 0; k < n; k++) expv[d][n-1-k] = exp_bit(d, word[d], k);
    end
    for (int k = 0; k < n; k++) begin
      bclk_period(lv, oa, ob);
      obsv[0] = {obsv[0][62:0], oa};
      obsv[1] = {obsv[1][62:0], ob};
    end
    check($sformatf("slot%0d_i2s", slot_no), obsv[0], expv[0]);
    check($sformatf("slot%0d_lj", slot_no), obsv[1], expv[1]);
  endtask

  initial begin
    logic oa, ob;
    logic [63:0] obs_a, obs_b;
    rst_n = 1'b0; bclk = 1'b1; lrck = 1'b0;
    valid_a = 1'b0; left_a = '0; right_a = '0;
    valid_b = 1'b0; left_b = '0; right_b = '0;
    utot[0] = 0; utot[1] = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_dat_a", dat_a, 0);
    check("rst_dat_b", dat_b, 0);
    check("rst_ready_a", ready_a, 1);
    check("rst_level_a", level_a, 0);
    check("rst_underrun_a", und_a, 0);
    check("rst_ucount_a", ucount_a, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Basic frame, then underrun: I2S holds last frame, LJ sends zeros
    push(0, 32'hA5C3, 32'h3C5A);
    push(1, 32'hA5C3F0, 32'h3C5A0F);
    idle();
    check("level_after_push_a", level_a, 1);
    slot(1, 32); slot(0, 32); slot(1, 32); slot(0, 32); slot(1, 32);
    check("ucount_a_t1", ucount_a, ucnt[0]);
    check("ucount_b_t1", ucount_b, ucnt[1]);

    // Short slots truncate the words
    push(0, 32'h1234, 32'h5678);
    push(0, 32'h9ABC, 32'hDEF0);
    push(1, 32'hF0E1D2, 32'hC3B4A5);
    idle();
    slot(0, 16); slot(1, 16); slot(0, 16); slot(1, 16);
    check("ucount_a_t2", ucount_a, ucnt[0]);

    // Backpressure: fill with no BCLK activity, then drain in order
    push(0, 32'h1111, 32'h2222);
    push(0, 32'h3333, 32'h4444);
    push(0, 32'h5555, 32'h6666);
    push(0, 32'h7777, 32'h8888);
    @(negedge clk);
    valid_a = 1'b1; left_a = 16'hDEAD; right_a = 16'hBEEF;
    repeat (6) @(negedge clk);
    valid_a = 1'b0;
    check("bp_level_full", level_a, 4);
    check("bp_ready_full", ready_a, 0);
    slot(0, 32);
    check("bp_level_after_pop", level_a, 3);
    check("bp_ready_after_pop", ready_a, 1);
    slot(1, 32); slot(0, 32); slot(1, 32); slot(0, 32); slot(1, 32); slot(0, 32); slot(1, 32);
    check("ucount_a_t3", ucount_a, ucnt[0]);

    // Reset in the middle of a left slot
    push(0, 32'hC3C3, 32'h3C3C);
    idle();
    for (int i = 0; i < 6; i++) bclk_period(1'b0, oa, ob);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_dat_a", dat_a, 0);
    check("midrst_level_a", level_a, 0);
    check("midrst_ready_a", ready_a, 1);
    model_reset();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    obs_a = '0; obs_b = '0;
    for (int i = 0; i < 26; i++) begin
      bclk_period(1'b0, oa, ob);
      obs_a = {obs_a[62:0], oa};
      obs_b = {obs_b[62:0], ob};
    end
    check("post_rst_quiet_a", obs_a, 0);
    check("post_rst_quiet_b", obs_b, 0);
    push(0, 32'h0F0F, 32'hF0F0);
    idle();
    slot(1, 32); slot(0, 32); slot(1, 32);

    check("ucount_a_end", ucount_a, ucnt[0]);
    check("ucount_b_end", ucount_b, ucnt[1]);
    check("pulse_cycles_a", ucyc_a, utot[0]);
    check("pulse_cycles_b", ucyc_b, utot[1]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
